// File: rtl/switch_traverse.sv
// switch_traverse: 5x5 crossbar traversal with lowest-index arbitration plus a multi-push bypass FIFO; 1-cycle latency.
// Bypass side is valid/ready; pushes beyond free slots are dropped. Macro SWITCH_TRAVERSE_CONFLICT_CHECK_EN enables err_conflict.
module switch_traverse #(
  parameter int FLIT_W    = 64,
  parameter int BYP_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [5*FLIT_W-1:0]          flit_in,
  input  logic [4:0]                   valid_in,
  input  logic [29:0]                  pv_in,
  output logic [5*FLIT_W-1:0]          flit_out,
  output logic [4:0]                   valid_out,
  output logic [FLIT_W-1:0]            byp_flit,
  output logic                         byp_valid,
  input  logic                         byp_ready,
  output logic [$clog2(BYP_DEPTH):0]   byp_count,
  output logic [7:0]                   drop_cnt,
  output logic                         err_conflict
);
  localparam int PW = $clog2(BYP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BYP_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
`ifdef SWITCH_TRAVERSE_CONFLICT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [5*FLIT_W-1:0] flit_out_q, flit_out_d;
  logic [4:0]          valid_out_q, valid_out_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [7:0]          drop_q, drop_d;
  logic                err_q, err_d;
  logic [FLIT_W-1:0]   mem_q [BYP_DEPTH];

  logic [5:0]          pv [5];
  logic [4:0]          fwd;
  logic [4:0]          byp_req, byp_acc;
  logic [PW-1:0]       byp_off [5];
  logic                pop;
  logic [CW-1:0]       free_slots, acc_n;
  logic [3:0]          drops;
  logic                found;
  logic                event_seen;
  logic [8:0]          drop_sum;

  always_comb begin
    flit_out_d  = flit_out_q;
    valid_out_d = '0;
    drops       = '0;
    event_seen  = 1'b0;
    found       = 1'b0;
    fwd         = '0;
    byp_req     = '0;
    byp_acc     = '0;
    acc_n       = '0;
    for (int i = 0; i < 5; i++) begin
      pv[i]      = pv_in[i*6 +: 6];
      byp_off[i] = '0;
    end

    // Classify each valid channel: bypass, single output port, or malformed.
    for (int i = 0; i < 5; i++) begin
      if (valid_in[i]) begin
        if (pv[i] == 6'b100000) begin
          byp_req[i] = 1'b1;
        end else if (!pv[i][5] && ($countones(pv[i][4:0]) == 1)) begin
          fwd[i] = 1'b1;
        end else begin
          drops      = drops + 4'd1;
          event_seen = 1'b1;
        end
      end
    end

    for (int p = 0; p < 5; p++) begin
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (fwd[i] && pv[i][p]) begin
          if (!found) begin
            found          = 1'b1;
            valid_out_d[p] = 1'b1;
            flit_out_d[p*FLIT_W +: FLIT_W] = flit_in[i*FLIT_W +: FLIT_W];
          end else begin
            drops      = drops + 4'd1;
            event_seen = 1'b1;
          end
        end
      end
    end

    // A same-cycle pop frees one slot for this cycle's pushes.
    pop        = (count_q != '0) && byp_ready;
    free_slots = DEPTH_C - count_q + {{(CW-1){1'b0}}, pop};
    for (int i = 0; i < 5; i++) begin
      if (byp_req[i]) begin
        if (acc_n < free_slots) begin
          byp_acc[i] = 1'b1;
          byp_off[i] = acc_n[PW-1:0];
          acc_n      = acc_n + ONE_C;
        end else begin
          drops = drops + 4'd1;
        end
      end
    end

    wr_ptr_d = wr_ptr_q + acc_n[PW-1:0];
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    count_d  = count_q + acc_n - (pop ? ONE_C : '0);
    drop_sum = {1'b0, drop_q} + {5'd0, drops};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    err_d    = CHECK_EN ? (err_q | event_seen) : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flit_out_q  <= '0;
      valid_out_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      flit_out_q  <= flit_out_d;
      valid_out_q <= valid_out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (byp_acc[i]) begin
        mem_q[wr_ptr_q + byp_off[i]] <= flit_in[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign flit_out     = flit_out_q;
  assign valid_out    = valid_out_q;
  assign byp_flit     = mem_q[rd_ptr_q];
  assign byp_valid    = (count_q != '0);
  assign byp_count    = count_q;
  assign drop_cnt     = drop_q;
  assign err_conflict = err_q;

endmodule

// File: tb/tb_switch_traverse.sv
// Directed bench for switch_traverse with a queue-based reference model compared every cycle.
module tb_switch_traverse;
  localparam int FLIT_W    = 64;
  localparam int BYP_DEPTH = 8;
`ifdef SWITCH_TRAVERSE_CONFLICT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [5:0] BP = 6'b100000;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [5*FLIT_W-1:0]   flit_in;
  logic [4:0]            valid_in;
  logic [29:0]           pv_in;
  logic [5*FLIT_W-1:0]   flit_out;
  logic [4:0]            valid_out;
  logic [FLIT_W-1:0]     byp_flit;
  logic                  byp_valid;
  logic                  byp_ready;
  logic [3:0]            byp_count;
  logic [7:0]            drop_cnt;
  logic                  err_conflict;

  switch_traverse #(.FLIT_W(FLIT_W), .BYP_DEPTH(BYP_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .valid_in(valid_in), .pv_in(pv_in),
    .flit_out(flit_out), .valid_out(valid_out), .byp_flit(byp_flit), .byp_valid(byp_valid),
    .byp_ready(byp_ready), .byp_count(byp_count), .drop_cnt(drop_cnt), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a flit queue and per-port registers updated from the routing rules.
  logic [FLIT_W-1:0] m_out [5];
  logic [4:0]        m_vld;
  logic [FLIT_W-1:0] m_q [$];
  int                m_drop;
  bit                m_err;
  int                md;
  bit                mev;
  bit   [4:0]        mtaken;
  logic [5:0]        mpv;
  logic [FLIT_W-1:0] mf;
  int                mport;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_vld = '0;
      for (int p = 0; p < 5; p++) m_out[p] = '0;
      m_q.delete();
      m_drop = 0;
      m_err  = 1'b0;
    end else begin
      md = 0; mev = 1'b0; mtaken = '0; m_vld = '0;
      if (m_q.size() > 0 && byp_ready) void'(m_q.pop_front());
      for (int i = 0; i < 5; i++) begin
        if (valid_in[i]) begin
          mpv = pv_in[i*6 +: 6];
          mf  = flit_in[i*FLIT_W +: FLIT_W];
          mport = -1;
          for (int b = 0; b < 5; b++) if (mpv == (6'd1 << b)) mport = b;
          if (mpv == BP) begin
            if (m_q.size() < BYP_DEPTH) m_q.push_back(mf);
            else md++;
          end else if (mport >= 0) begin
            if (mtaken[mport]) begin md++; mev = 1'b1; end
            else begin mtaken[mport] = 1'b1; m_out[mport] = mf; m_vld[mport] = 1'b1; end
          end else begin
            md++; mev = 1'b1;
          end
        end
      end
      m_drop = (m_drop + md > 255) ? 255 : m_drop + md;
      if (ERR_EN && mev) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checking && reset_n) begin
      chk("valid_out", 64'(valid_out), 64'(m_vld));
      for (int p = 0; p < 5; p++) chk($sformatf("flit_out[%0d]", p), flit_out[p*FLIT_W +: FLIT_W], m_out[p]);
      chk("byp_valid", 64'(byp_valid), 64'(m_q.size() > 0));
      chk("byp_count", 64'(byp_count), 64'(m_q.size()));
      if (m_q.size() > 0) chk("byp_flit", byp_flit, m_q[0]);
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("err_conflict", 64'(err_conflict), 64'(m_err));
    end
  end

  function automatic logic [29:0] pvv(input logic [5:0] p4, p3, p2, p1, p0);
    return {p4, p3, p2, p1, p0};
  endfunction

  // Drive one cycle of inputs (called at a falling edge), flit of channel i = base+i.
  task automatic step(input logic [4:0] v, input logic [29:0] pv, input logic [15:0] base, input logic rdy);
    valid_in  = v;
    pv_in     = pv;
    byp_ready = rdy;
    for (int i = 0; i < 5; i++) flit_in[i*FLIT_W +: FLIT_W] = 64'(base) + 64'(i);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; valid_in = '0; pv_in = '0; byp_ready = 1'b0; flit_in = '0;
    repeat (2) @(negedge clk);
    chk("rst valid_out", 64'(valid_out), 64'd0);
    chk("rst byp_valid", 64'(byp_valid), 64'd0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    reset_n  = 1'b1;
    checking = 1'b1;

    step(5'b00011, pvv(6'd0, 6'd0, 6'd0, 6'b000100, 6'b000010), 16'h1000, 1'b0);
    chk("route valid_out", 64'(valid_out), 64'h06);
    chk("route port1", flit_out[1*FLIT_W +: FLIT_W], 64'h1000);
    chk("route port2", flit_out[2*FLIT_W +: FLIT_W], 64'h1001);
    step(5'b00000, '1, 16'h1100, 1'b0);
    chk("idle valid_out", 64'(valid_out), 64'h00);
    chk("idle port1 hold", flit_out[1*FLIT_W +: FLIT_W], 64'h1000);

    step(5'b01001, pvv(6'd0, 6'b000001, 6'd0, 6'd0, 6'b000001), 16'h2000, 1'b0);
    chk("conflict port0", flit_out[0 +: FLIT_W], 64'h2000);
    chk("conflict drop_cnt", 64'(drop_cnt), 64'd1);
    chk("conflict err", 64'(err_conflict), 64'(ERR_EN));

    step(5'b00110, pvv(6'd0, 6'd0, 6'b000011, 6'd0, 6'b000001), 16'h2100, 1'b0);
    chk("malformed drop_cnt", 64'(drop_cnt), 64'd3);
    chk("malformed valid_out", 64'(valid_out), 64'h00);

    step(5'b10110, pvv(BP, 6'd0, BP, BP, 6'd0), 16'h3000, 1'b0);
    chk("byp count3", 64'(byp_count), 64'd3);
    chk("byp head ch1", byp_flit, 64'h3001);
    step(5'b00000, '0, 16'h0, 1'b1);
    chk("byp head ch2", byp_flit, 64'h3002);
    step(5'b00000, '0, 16'h0, 1'b1);
    chk("byp head ch4", byp_flit, 64'h3004);
    step(5'b00000, '0, 16'h0, 1'b1);
    chk("byp empty", 64'(byp_valid), 64'd0);
    step(5'b00000, '0, 16'h0, 1'b1);
    chk("byp no underflow", 64'(byp_count), 64'd0);

    step(5'b11111, {5{BP}}, 16'h4000, 1'b0);
    step(5'b00001, {5{BP}}, 16'h4100, 1'b0);
    chk("ovf pre count", 64'(byp_count), 64'd6);
    step(5'b11111, {5{BP}}, 16'h4200, 1'b0);
    chk("ovf count", 64'(byp_count), 64'd8);
    chk("ovf drop_cnt", 64'(drop_cnt), 64'd6);
    step(5'b00001, {5{BP}}, 16'h4300, 1'b1);
    chk("full push+pop count", 64'(byp_count), 64'd8);
    chk("full push+pop drop", 64'(drop_cnt), 64'd6);
    chk("full push+pop head", byp_flit, 64'h4001);

    repeat (3) step(5'b00001, pvv(6'd0, 6'd0, 6'd0, 6'd0, 6'b001000), 16'h4400, 1'b1);
    chk("pre-reset count", 64'(byp_count), 64'd5);
    chk("pre-reset valid_out", 64'(valid_out), 64'h08);

    valid_in = '0; byp_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst byp_valid", 64'(byp_valid), 64'd0);
    chk("async rst byp_count", 64'(byp_count), 64'd0);
    chk("async rst valid_out", 64'(valid_out), 64'd0);
    chk("async rst drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    step(5'b10000, pvv(6'b000001, 6'd0, 6'd0, 6'd0, 6'd0), 16'h5000, 1'b0);
    chk("post-reset valid_out", 64'(valid_out), 64'h01);
    chk("post-reset port0", flit_out[0 +: FLIT_W], 64'h5004);

    repeat (52) step(5'b11111, '0, 16'h6000, 1'b0);
    chk("drop saturate", 64'(drop_cnt), 64'd255);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
